// File: rtl/kart_motion_if.sv
// Terrain-map query bus: kart side issues a candidate position, map side answers.
interface kart_motion_if;
  logic        req;
  logic [10:0] x;
  logic [10:0] y;
  logic        valid;
  logic        offroad;
  logic        wall;

  modport master (output req, x, y, input valid, offroad, wall);
  modport slave  (input req, x, y, output valid, offroad, wall);
endinterface

// File: rtl/kart_motion.sv
// Per-frame kart physics: steer/throttle into shadow state, move, ask the terrain map, then commit.
module kart_motion #(
  parameter int MAX_SPEED     = 15,
  parameter int OFFROAD_MAX   = 6,
  parameter int ACCEL         = 1,
  parameter int COAST_DEC     = 1,
  parameter int START_X       = 1960,
  parameter int START_Y       = 1960,
  parameter int START_HEADING = 0,
  parameter int TRACK_MAX     = 2047,
  parameter int TIMEOUT       = 63
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          frame_in,
  input  logic          btn_gas,
  input  logic          btn_brake,
  input  logic          btn_left,
  input  logic          btn_right,
  kart_motion_if.master terrain,
  output logic [10:0]   player_x,
  output logic [10:0]   player_y,
  output logic [3:0]    heading_out,
  output logic [3:0]    speed_out,
  output logic          busy_out,
  output logic          overrun_out
);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [14:0]        POS_X0  = 15'(START_X * 16);
  localparam logic [14:0]        POS_Y0  = 15'(START_Y * 16);
  localparam logic signed [16:0] POS_MAX = 17'(TRACK_MAX * 16 + 15);

  typedef enum logic [2:0] {IDLE, STEER, MOVE, LOOKUP, COMMIT} state_t;

  state_t        state;
  logic [14:0]   pos_x, pos_y, cand_x, cand_y, step_x, step_y;
  logic [3:0]    heading, speed, sh_heading, sh_speed;
  logic          offroad, lookup_req, busy, overrun, ans_wall, ans_off;
  logic [TW-1:0] tmo;
  logic [10:0]   look_x, look_y;

  function automatic logic signed [5:0] cos_lut(input logic [3:0] h);
    logic signed [5:0] c;
    case (h)
      4'd0:    c = 6'sd16;
      4'd1:    c = 6'sd15;
      4'd2:    c = 6'sd11;
      4'd3:    c = 6'sd6;
      4'd4:    c = 6'sd0;
      4'd5:    c = -6'sd6;
      4'd6:    c = -6'sd11;
      4'd7:    c = -6'sd15;
      4'd8:    c = -6'sd16;
      4'd9:    c = -6'sd15;
      4'd10:   c = -6'sd11;
      4'd11:   c = -6'sd6;
      4'd12:   c = 6'sd0;
      4'd13:   c = 6'sd6;
      4'd14:   c = 6'sd11;
      default: c = 6'sd15;
    endcase
    return c;
  endfunction

  function automatic logic [3:0] steer_heading(input logic [3:0] h, input logic [3:0] spd,
                                               input logic l, input logic r);
    if (spd == 4'd0 || l == r) return h;
    return l ? h - 4'd1 : h + 4'd1;
  endfunction

  // Brake beats gas; an over-cap kart (just went offroad) bleeds ACCEL per frame down to the cap.
  function automatic logic [3:0] next_speed(input logic [3:0] spd, input logic gas,
                                            input logic brake, input logic off);
    int s, cap;
    s   = int'(spd);
    cap = off ? OFFROAD_MAX : MAX_SPEED;
    if (brake) begin
      s = s - 2 * ACCEL;
      if (s < 0) s = 0;
    end else if (s > cap) begin
      s = s - ACCEL;
      if (s < cap) s = cap;
    end else if (gas) begin
      s = s + ACCEL;
      if (s > cap) s = cap;
    end else begin
      s = s - COAST_DEC;
      if (s < 0) s = 0;
    end
    return 4'(s);
  endfunction

  function automatic logic [14:0] step_pos(input logic [14:0] p, input logic [3:0] spd,
                                           input logic signed [5:0] c);
    logic signed [16:0] p_s, spd_s, c_s, sum;
    p_s   = {2'b00, p};
    spd_s = {13'd0, spd};
    c_s   = {{11{c[5]}}, c};
    sum   = p_s + spd_s * c_s;
    if (sum < 17'sd0)   return '0;
    if (sum > POS_MAX)  return POS_MAX[14:0];
    return sum[14:0];
  endfunction

  assign step_x = step_pos(pos_x, sh_speed, cos_lut(sh_heading));
  assign step_y = step_pos(pos_y, sh_speed, cos_lut(sh_heading - 4'd4));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state      <= IDLE;
      pos_x      <= POS_X0;
      pos_y      <= POS_Y0;
      heading    <= 4'(START_HEADING);
      speed      <= '0;
      offroad    <= 1'b0;
      tmo        <= '0;
      lookup_req <= 1'b0;
      look_x     <= 11'(START_X);
      look_y     <= 11'(START_Y);
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (frame_in && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (frame_in) begin
          state <= STEER;
          busy  <= 1'b1;
        end
        STEER: state <= MOVE;
        MOVE: begin
          state      <= LOOKUP;
          lookup_req <= 1'b1;
          tmo        <= '0;
          look_x     <= step_x[14:4];
          look_y     <= step_y[14:4];
        end
        LOOKUP: begin
          if (terrain.valid || tmo == TW'(TIMEOUT)) begin
            state      <= COMMIT;
            lookup_req <= 1'b0;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        COMMIT: begin
          state   <= IDLE;
          busy    <= 1'b0;
          heading <= sh_heading;
          if (ans_wall) begin
            speed <= '0;
          end else begin
            pos_x   <= cand_x;
            pos_y   <= cand_y;
            speed   <= sh_speed;
            offroad <= ans_off;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shadow state is always rewritten before use within a frame, so it carries no reset.
  always_ff @(posedge clk_in) begin
    case (state)
      STEER: begin
        sh_heading <= steer_heading(heading, speed, btn_left, btn_right);
        sh_speed   <= next_speed(speed, btn_gas, btn_brake, offroad);
      end
      MOVE: begin
        cand_x <= step_x;
        cand_y <= step_y;
      end
      LOOKUP: begin
        if (terrain.valid) begin
          ans_wall <= terrain.wall;
          ans_off  <= terrain.offroad;
        end else if (tmo == TW'(TIMEOUT)) begin
          ans_wall <= 1'b0;
          ans_off  <= 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign terrain.req = lookup_req;
  assign terrain.x   = look_x;
  assign terrain.y   = look_y;
  assign player_x    = pos_x[14:4];
  assign player_y    = pos_y[14:4];
  assign heading_out = heading;
  assign speed_out   = speed;
  assign busy_out    = busy;
  assign overrun_out = overrun;
endmodule

// File: tb/tb_kart_motion.sv
// Directed bench for kart_motion: scripted frames with a scripted terrain responder.
module tb_kart_motion;
  logic        clk = 1'b0;
  logic        rst_n, frame, gas, brake, left, right;
  logic [10:0] px, py;
  logic [3:0]  hd, sp;
  logic        busy, ovr;
  int          checks = 0;
  int          errors = 0;
  int          rc;

  always #5 clk = ~clk;

  kart_motion_if tif ();

  kart_motion dut (
    .clk_in(clk), .rst_in(rst_n), .frame_in(frame),
    .btn_gas(gas), .btn_brake(brake), .btn_left(left), .btn_right(right),
    .terrain(tif),
    .player_x(px), .player_y(py), .heading_out(hd), .speed_out(sp),
    .busy_out(busy), .overrun_out(ovr)
  );

  // One full frame. dly<0: never answer (timeout path). dbl: second frame pulse while busy.
  task automatic run_frame(input bit g, input bit b, input bit l, input bit r, input int dly,
                           input bit off, input bit wl, input bit dbl, output int req_cycles);
    int n;
    @(negedge clk);
    gas = g; brake = b; left = l; right = r; frame = 1'b1;
    req_cycles = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      frame = (n == 1) ? dbl : 1'b0;
      tif.valid = 1'b0; tif.offroad = 1'b0; tif.wall = 1'b0;
      if (tif.req) begin
        req_cycles++;
        if (dly >= 0 && req_cycles == dly + 1) begin
          tif.valid = 1'b1; tif.offroad = off; tif.wall = wl;
        end
      end
    end while (busy && n < 200);
    tif.valid = 1'b0; tif.offroad = 1'b0; tif.wall = 1'b0;
    gas = 1'b0; brake = 1'b0; left = 1'b0; right = 1'b0; frame = 1'b0;
    checks++;
    if (n >= 200) begin errors++; $display("FAIL frame_done busy still %0d after %0d cycles", busy, n); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; frame = 0; gas = 0; brake = 0; left = 0; right = 0;
    tif.valid = 0; tif.offroad = 0; tif.wall = 0;
    repeat (3) @(negedge clk);
    checks++; if (px !== 11'd1960) begin errors++; $display("FAIL reset_x got %0d want 1960", px); end
    checks++; if (py !== 11'd1960) begin errors++; $display("FAIL reset_y got %0d want 1960", py); end
    checks++; if ({hd, sp} !== 8'h00) begin errors++; $display("FAIL reset_hd_sp got %0d/%0d want 0/0", hd, sp); end
    checks++; if ({busy, ovr, tif.req} !== 3'b000) begin errors++; $display("FAIL reset_ctl got %b want 000", {busy, ovr, tif.req}); end
    checks++; if ({tif.x, tif.y} !== {11'd1960, 11'd1960}) begin errors++; $display("FAIL reset_txy got %0d/%0d want 1960/1960", tif.x, tif.y); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_latency;
    @(negedge clk); gas = 1'b1; frame = 1'b1;
    @(negedge clk); frame = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (tif.req !== 1'b1) begin errors++; $display("FAIL lat_req got %0d want 1", tif.req); end
    checks++; if ({tif.x, tif.y} !== {11'd1961, 11'd1960}) begin errors++; $display("FAIL lat_cand got %0d/%0d want 1961/1960", tif.x, tif.y); end
    tif.valid = 1'b1;
    @(negedge clk); tif.valid = 1'b0;
    checks++; if (px !== 11'd1960 || busy !== 1'b1 || tif.req !== 1'b0) begin errors++; $display("FAIL lat_early got x=%0d busy=%0d req=%0d want 1960/1/0", px, busy, tif.req); end
    @(negedge clk); gas = 1'b0;
    checks++; if (px !== 11'd1961 || sp !== 4'd1 || busy !== 1'b0) begin errors++; $display("FAIL lat_commit got x=%0d sp=%0d busy=%0d want 1961/1/0", px, sp, busy); end
    checks++; if (py !== 11'd1960) begin errors++; $display("FAIL lat_y got %0d want 1960", py); end
  endtask

  task automatic test_accel;
    for (int i = 0; i < 11; i++) run_frame(1, 0, 0, 0, 0, 0, 0, 0, rc);
    checks++; if (px !== 11'd2038 || sp !== 4'd12) begin errors++; $display("FAIL accel_12 got x=%0d sp=%0d want 2038/12", px, sp); end
    run_frame(1, 0, 0, 0, 0, 0, 0, 0, rc);
    checks++; if (px !== 11'd2047 || sp !== 4'd13) begin errors++; $display("FAIL clamp_xmax got x=%0d sp=%0d want 2047/13", px, sp); end
    run_frame(1, 0, 0, 0, 1, 0, 0, 0, rc);
    run_frame(1, 0, 0, 0, 2, 0, 0, 0, rc);
    checks++; if (sp !== 4'd15) begin errors++; $display("FAIL accel_15 got %0d want 15", sp); end
    run_frame(1, 0, 0, 0, 0, 0, 0, 0, rc);
    checks++; if (sp !== 4'd15 || px !== 11'd2047 || py !== 11'd1960) begin errors++; $display("FAIL accel_cap got sp=%0d x=%0d y=%0d want 15/2047/1960", sp, px, py); end
  endtask

  task automatic test_steer;
    run_frame(0, 0, 1, 0, 0, 0, 0, 0, rc);
    checks++; if (hd !== 4'd15 || sp !== 4'd14) begin errors++; $display("FAIL steer_left got h=%0d sp=%0d want 15/14", hd, sp); end
    checks++; if (px !== 11'd2047 || py !== 11'd1954) begin errors++; $display("FAIL steer_pos got %0d/%0d want 2047/1954", px, py); end
    run_frame(0, 0, 0, 1, 0, 0, 0, 0, rc);
    checks++; if (hd !== 4'd0 || sp !== 4'd13) begin errors++; $display("FAIL steer_right got h=%0d sp=%0d want 0/13", hd, sp); end
    for (int i = 0; i < 7; i++) run_frame(0, 1, 0, 0, 0, 0, 0, 0, rc);
    checks++; if (sp !== 4'd0 || py !== 11'd1954) begin errors++; $display("FAIL brake_floor got sp=%0d y=%0d want 0/1954", sp, py); end
    run_frame(0, 0, 0, 1, 0, 0, 0, 0, rc);
    checks++; if (hd !== 4'd0 || sp !== 4'd0) begin errors++; $display("FAIL steer_stopped got h=%0d sp=%0d want 0/0", hd, sp); end
  endtask

  task automatic test_clamp;
    run_frame(1, 0, 0, 0, 0, 0, 0, 0, rc);
    for (int i = 0; i < 8; i++) run_frame(1, 0, 1, 0, 0, 0, 0, 0, rc);
    checks++; if (hd !== 4'd8 || sp !== 4'd9) begin errors++; $display("FAIL turn_h8 got h=%0d sp=%0d want 8/9", hd, sp); end
    for (int i = 0; i < 150; i++) run_frame(1, 0, 0, 0, 0, 0, 0, 0, rc);
    checks++; if (px !== 11'd0 || sp !== 4'd15) begin errors++; $display("FAIL clamp_x0 got x=%0d sp=%0d want 0/15", px, sp); end
    for (int i = 0; i < 4; i++) run_frame(1, 0, 0, 1, 0, 0, 0, 0, rc);
    for (int i = 0; i < 150; i++) run_frame(1, 0, 0, 0, 0, 0, 0, 0, rc);
    checks++; if (px !== 11'd0 || py !== 11'd0 || hd !== 4'd12) begin errors++; $display("FAIL clamp_y0 got x=%0d y=%0d h=%0d want 0/0/12", px, py, hd); end
    for (int i = 0; i < 8; i++) run_frame(1, 0, 0, 1, 0, 0, 0, 0, rc);
    for (int i = 0; i < 150; i++) run_frame(1, 0, 0, 0, 0, 0, 0, 0, rc);
    checks++; if (px !== 11'd75 || py !== 11'd2047 || hd !== 4'd4) begin errors++; $display("FAIL clamp_ymax got x=%0d y=%0d h=%0d want 75/2047/4", px, py, hd); end
  endtask

  task automatic test_offroad;
    int exp_sp;
    run_frame(1, 0, 0, 0, 0, 1, 0, 0, rc);
    checks++; if (sp !== 4'd15) begin errors++; $display("FAIL off_enter got %0d want 15", sp); end
    for (int i = 0; i < 10; i++) begin
      exp_sp = (14 - i < 6) ? 6 : 14 - i;
      run_frame(1, 0, 0, 0, 0, 1, 0, 0, rc);
      checks++; if (sp !== 4'(exp_sp)) begin errors++; $display("FAIL off_decay%0d got %0d want %0d", i, sp, exp_sp); end
    end
    run_frame(1, 1, 0, 0, 0, 1, 0, 0, rc);
    checks++; if (sp !== 4'd4) begin errors++; $display("FAIL brake_wins got %0d want 4", sp); end
    run_frame(1, 0, 0, 0, 0, 1, 0, 0, rc);
    checks++; if (sp !== 4'd5 || px !== 11'd75 || py !== 11'd2047) begin errors++; $display("FAIL off_gas got sp=%0d x=%0d y=%0d want 5/75/2047", sp, px, py); end
  endtask

  task automatic test_timeout;
    run_frame(1, 0, 0, 0, -1, 0, 0, 0, rc);
    checks++; if (rc !== 64) begin errors++; $display("FAIL tmo_req_cycles got %0d want 64", rc); end
    checks++; if (sp !== 4'd6) begin errors++; $display("FAIL tmo_speed got %0d want 6", sp); end
    run_frame(1, 0, 0, 0, 0, 0, 0, 0, rc);
    checks++; if (sp !== 4'd7) begin errors++; $display("FAIL tmo_onroad got %0d want 7", sp); end
  endtask

  task automatic test_wall;
    run_frame(1, 0, 1, 0, 0, 0, 1, 0, rc);
    checks++; if (sp !== 4'd0 || hd !== 4'd3) begin errors++; $display("FAIL wall_sp_h got sp=%0d h=%0d want 0/3", sp, hd); end
    checks++; if (px !== 11'd75 || py !== 11'd2047) begin errors++; $display("FAIL wall_pos got %0d/%0d want 75/2047", px, py); end
  endtask

  task automatic test_overrun;
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL ovr_pre got %0d want 0", ovr); end
    run_frame(1, 0, 0, 0, 0, 0, 0, 1, rc);
    checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL ovr_set got %0d want 1", ovr); end
    checks++; if (sp !== 4'd1 || hd !== 4'd3 || px !== 11'd75) begin errors++; $display("FAIL ovr_frame got sp=%0d h=%0d x=%0d want 1/3/75", sp, hd, px); end
    repeat (5) @(negedge clk);
    checks++; if (busy !== 1'b0 || tif.req !== 1'b0 || ovr !== 1'b1) begin errors++; $display("FAIL ovr_ignored got busy=%0d req=%0d ovr=%0d want 0/0/1", busy, tif.req, ovr); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk); gas = 1'b1; frame = 1'b1;
    @(negedge clk); frame = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (tif.req !== 1'b1) begin errors++; $display("FAIL rst_mid_req got %0d want 1", tif.req); end
    rst_n = 1'b0;
    #1;
    checks++; if (tif.req !== 1'b0 || busy !== 1'b0 || ovr !== 1'b0) begin errors++; $display("FAIL rst_mid_ctl got req=%0d busy=%0d ovr=%0d want 0/0/0", tif.req, busy, ovr); end
    checks++; if (px !== 11'd1960 || py !== 11'd1960 || hd !== 4'd0 || sp !== 4'd0) begin errors++; $display("FAIL rst_mid_out got %0d/%0d h=%0d sp=%0d want 1960/1960/0/0", px, py, hd, sp); end
    checks++; if ({tif.x, tif.y} !== {11'd1960, 11'd1960}) begin errors++; $display("FAIL rst_mid_txy got %0d/%0d want 1960/1960", tif.x, tif.y); end
    @(negedge clk); rst_n = 1'b1; gas = 1'b0;
    @(negedge clk);
    run_frame(1, 0, 0, 0, 0, 0, 0, 0, rc);
    checks++; if (px !== 11'd1961 || sp !== 4'd1 || hd !== 4'd0) begin errors++; $display("FAIL rst_restart got x=%0d sp=%0d h=%0d want 1961/1/0", px, sp, hd); end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_accel;
    test_steer;
    test_clamp;
    test_offroad;
    test_timeout;
    test_wall;
    test_overrun;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
